// File: rtl/vuart_stream_bridge_if.sv
// vuart_stream_bridge_if
//   APB link between the stream bridge (master) and the virtual UART device
//   port (slave).
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready/pslverr            : slave  -> master
interface vuart_stream_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/vuart_stream_bridge.sv
// vuart_stream_bridge
//   APB master that feeds the virtual UART device port from a byte stream and
//   drains received bytes back to a byte stream. It polls STAT, then writes
//   or reads the FIFO register when the UART reports space or data.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     tx_data/valid/ready byte stream into the UART (1-entry holding reg)
//     rx_data/valid/ready byte stream out of the UART (1-entry holding reg)
//     apbm                APB master (vuart_stream_bridge_if.master)
//     err                 one-cycle pulse for any transfer ending in pslverr
//   Optional: define VUART_BRIDGE_CRLF_EN to expand each 8'h0A into
//   8'h0D, 8'h0A on the wire.
module vuart_stream_bridge #(
  parameter logic [15:0] ADDR_STAT      = 16'h0000,
  parameter logic [15:0] ADDR_FIFO      = 16'h0008,
  parameter int          STAT_RXVLD_BIT = 0,
  parameter int          STAT_TXRDY_BIT = 1,
  parameter logic [7:0]  POLL_INTERVAL  = 8'd15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  vuart_stream_bridge_if.master       apbm,
  output logic                        err
);

  // The IDLE cycle that always follows a fruitless poll is itself one of the
  // idle cycles, so the counter is loaded one short of the interval.
  localparam logic [7:0] POLL_RELOAD = (POLL_INTERVAL == 8'd0) ? 8'd0
                                                                : POLL_INTERVAL - 8'd1;

  typedef enum logic [2:0] {IDLE, STAT_SETUP, STAT_ACCESS, XFER_SETUP, XFER_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        prio_rx_q, prio_rx_d;   // 0: TX wins the next tie
  logic        xfer_tx_q, xfer_tx_d;   // direction of the FIFO transfer
  logic        err_q, err_d;
  logic [7:0]  tx_hold_q;
  logic        tx_hold_vld_q;
  logic [7:0]  rx_data_q;
  logic        rx_hold_vld_q;

  logic        tx_fire, tx_done, rx_load;
  logic        tx_ok, rx_ok;
  logic        send_cr;
  logic [7:0]  wbyte;

  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;

`ifdef VUART_BRIDGE_CRLF_EN
  logic        cr_sent_q;
  // A held LF goes out as CR first; cr_sent_q marks that the CR is done.
  assign send_cr = (tx_hold_q == 8'h0A) && !cr_sent_q;
`else
  assign send_cr = 1'b0;
`endif
  assign wbyte = send_cr ? 8'h0D : tx_hold_q;

  assign tx_ready = !tx_hold_vld_q;
  assign tx_fire  = tx_valid && !tx_hold_vld_q;
  assign rx_valid = rx_hold_vld_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;

  assign tx_ok = tx_hold_vld_q && apbm.prdata[STAT_TXRDY_BIT];
  assign rx_ok = !rx_hold_vld_q && apbm.prdata[STAT_RXVLD_BIT];

  assign apbm.psel    = psel;
  assign apbm.penable = penable;
  assign apbm.pwrite  = pwrite;
  assign apbm.paddr   = paddr;
  assign apbm.pwdata  = pwdata;

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    prio_rx_d  = prio_rx_q;
    xfer_tx_d  = xfer_tx_q;
    err_d      = 1'b0;
    tx_done    = 1'b0;
    rx_load    = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = '0;
    pwdata     = '0;
    case (state_q)
      IDLE: begin
        if (poll_cnt_q != 8'd0 && !tx_fire)
          poll_cnt_d = poll_cnt_q - 8'd1;
        else if (tx_hold_vld_q || tx_fire || !rx_hold_vld_q)
          state_d = STAT_SETUP;
      end
      STAT_SETUP: begin
        psel    = 1'b1;
        paddr   = ADDR_STAT;
        state_d = STAT_ACCESS;
      end
      STAT_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = ADDR_STAT;
        if (apbm.pready) begin
          if (apbm.pslverr) begin
            err_d      = 1'b1;
            poll_cnt_d = POLL_RELOAD;
            state_d    = IDLE;
          end else if (tx_ok && rx_ok) begin
            xfer_tx_d = !prio_rx_q;
            prio_rx_d = !prio_rx_q;
            state_d   = XFER_SETUP;
          end else if (tx_ok || rx_ok) begin
            xfer_tx_d = tx_ok;
            state_d   = XFER_SETUP;
          end else begin
            poll_cnt_d = POLL_RELOAD;
            state_d    = IDLE;
          end
        end
      end
      XFER_SETUP, XFER_ACCESS: begin
        psel    = 1'b1;
        penable = (state_q == XFER_ACCESS);
        pwrite  = xfer_tx_q;
        paddr   = ADDR_FIFO;
        pwdata  = xfer_tx_q ? {24'h0, wbyte} : 32'h0;
        if (state_q == XFER_SETUP) begin
          state_d = XFER_ACCESS;
        end else if (apbm.pready) begin
          state_d    = IDLE;
          poll_cnt_d = '0;
          if (apbm.pslverr) err_d   = 1'b1;
          else if (xfer_tx_q) tx_done = 1'b1;
          else rx_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh TX byte always restarts polling immediately.
    if (tx_fire) poll_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      poll_cnt_q    <= '0;
      prio_rx_q     <= 1'b0;
      xfer_tx_q     <= 1'b0;
      err_q         <= 1'b0;
      tx_hold_q     <= '0;
      tx_hold_vld_q <= 1'b0;
      rx_data_q     <= '0;
      rx_hold_vld_q <= 1'b0;
`ifdef VUART_BRIDGE_CRLF_EN
      cr_sent_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      prio_rx_q  <= prio_rx_d;
      xfer_tx_q  <= xfer_tx_d;
      err_q      <= err_d;
      if (tx_fire) begin
        tx_hold_q     <= tx_data;
        tx_hold_vld_q <= 1'b1;
      end else if (tx_done) begin
`ifdef VUART_BRIDGE_CRLF_EN
        if (send_cr) begin
          cr_sent_q <= 1'b1;
        end else begin
          cr_sent_q     <= 1'b0;
          tx_hold_vld_q <= 1'b0;
        end
`else
        tx_hold_vld_q <= 1'b0;
`endif
      end
      if (rx_load) begin
        rx_data_q     <= apbm.prdata[7:0];
        rx_hold_vld_q <= 1'b1;
      end else if (rx_hold_vld_q && rx_ready) begin
        rx_hold_vld_q <= 1'b0;
      end
    end
  end

endmodule
